// File: rtl/uart_tx_arb_pkg.sv
// Shared types, widths and the round-robin search used by the UART TX arbiter.
package uart_tx_arb_pkg;

    localparam int GID_W   = 3;
    localparam int MAX_REQ = 8;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_e;

    typedef struct packed {
        logic             found;
        logic [GID_W-1:0] idx;
    } pick_t;

    // First set bit of valid, searching ptr, ptr+1, ... modulo nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [GID_W-1:0]   ptr,
                                      input int                 nreq);
        pick_t res;
        int    k;
        res = '0;
        k   = 0;
        for (int o = 0; o < MAX_REQ; o++) begin
            if (o < nreq && !res.found) begin
                k = (int'(ptr) + o) % nreq;
                if (valid[k[GID_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = k[GID_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester byte streams and TX FIFO write port seen by the UART TX arbiter.
interface uart_tx_arb_if #(parameter int NREQ = 4);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][7:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_full;
    logic                 fifo_wr;
    logic [7:0]           fifo_wdata;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_wdata
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_wdata
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [GID_W-1:0] ptr,
    output logic             found,
    output logic [GID_W-1:0] idx
);

    logic [MAX_REQ-1:0] valid_ext;
    pick_t              pick;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, ptr, NREQ);
    end

    assign found = pick.found;
    assign idx   = pick.idx;

endmodule

// File: rtl/uart_tx_arb.sv
// Message-level round-robin arbiter in front of the UART TX FIFO write port.
// Optional idle-grant timeout release enabled by UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic             app_clk,
    input  logic             reset_n,
    input  logic             cfg_tx_enable,
    uart_tx_arb_if.slave     bus,
    output logic [GID_W-1:0] grant_id,
    output logic             busy,
    output logic             tmo_pulse
);

    arb_state_e       state, state_d;
    logic [GID_W-1:0] rr_ptr, rr_ptr_d, grant_d, pick_idx, next_ptr;
    logic             pick_found;
    logic [NREQ-1:0]  owner;
    logic             owner_valid, owner_last, xfer_any, xfer_last, tmo_hit;
    logic [7:0]       owner_data;

    uart_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // One-hot owner select avoids indexing NREQ-wide vectors with a 3-bit id.
    always_comb begin
        owner       = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner[i] = (grant_id == GID_W'(i));
            if (owner[i]) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[i];
            end
        end
    end

    assign bus.req_ready  = (state == LOCK && !bus.fifo_full && cfg_tx_enable) ? owner : '0;
    assign xfer_any       = |(bus.req_valid & bus.req_ready);
    assign xfer_last      = xfer_any & owner_last;
    assign bus.fifo_wr    = xfer_any;
    assign bus.fifo_wdata = xfer_any ? owner_data : 8'h00;
    assign busy           = (state == LOCK);
    assign next_ptr       = (grant_id == GID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC) + 1;

    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;

    // Fires on the cycle the counter would reach TMO_CYC-1; fifo_full stalls with valid high don't count.
    assign tmo_hit = (state == LOCK) && cfg_tx_enable && !owner_valid &&
                     (tmo_cnt == CNT_W'(TMO_CYC-2));

    always_comb begin
        tmo_cnt_d = tmo_cnt;
        if (state != LOCK || !cfg_tx_enable || xfer_any || tmo_hit)
            tmo_cnt_d = '0;
        else if (!owner_valid)
            tmo_cnt_d = tmo_cnt + 1'b1;
    end

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            tmo_pulse <= 1'b0;
        end else begin
            tmo_cnt   <= tmo_cnt_d;
            tmo_pulse <= tmo_hit;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign tmo_pulse = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        grant_d  = grant_id;
        rr_ptr_d = rr_ptr;
        if (!cfg_tx_enable) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    state_d = LOCK;
                    grant_d = pick_idx;
                end
                LOCK: if (xfer_last || tmo_hit) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            grant_id <= grant_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-requester message queues drive the bus, FIFO writes are logged.
module tb_uart_tx_arb;
    import uart_tx_arb_pkg::*;

    localparam int NREQ = 4;

    logic             app_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_tx_enable = 1'b0;
    logic [GID_W-1:0] grant_id;
    logic             busy, tmo_pulse;

    uart_tx_arb_if #(.NREQ(NREQ)) bus();

    uart_tx_arb #(.NREQ(NREQ), .TMO_CYC(16)) dut (
        .app_clk       (app_clk),
        .reset_n       (reset_n),
        .cfg_tx_enable (cfg_tx_enable),
        .bus           (bus),
        .grant_id      (grant_id),
        .busy          (busy),
        .tmo_pulse     (tmo_pulse)
    );

    always #5 app_clk = ~app_clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [8:0]      mq [NREQ][$];
    logic [10:0]     wq [$];
    logic [NREQ-1:0] xfer_n = '0;
    logic [NREQ-1:0] gate   = '0;
    logic            full_s = 1'b0;
    logic            en_s   = 1'b0;
    logic [63:0]     wpat, bpat, rpat;
    int              wcnt, bcnt, tcnt, tpos;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int r, input logic [7:0] first, input int len);
        for (int k = 0; k < len; k++)
            mq[r].push_back({(k == len-1), 8'(first + k)});
    endtask

    // Inputs change just after posedge; outputs and handshakes are sampled at negedge.
    task automatic cyc();
        @(posedge app_clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer_n[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            bus.req_valid[i] = (mq[i].size() > 0) && !gate[i];
            bus.req_last[i]  = (mq[i].size() > 0) ? mq[i][0][8] : 1'b0;
            bus.req_data[i]  = (mq[i].size() > 0) ? mq[i][0][7:0] : 8'h00;
        end
        bus.fifo_full = full_s;
        cfg_tx_enable = en_s;
        @(negedge app_clk);
        xfer_n = bus.req_valid & bus.req_ready;
        if (bus.fifo_wr) wq.push_back({grant_id, bus.fifo_wdata});
    endtask

    task automatic run(input int n);
        wpat = '0; bpat = '0; rpat = '0;
        wcnt = 0; bcnt = 0; tcnt = 0; tpos = -1;
        for (int c = 0; c < n; c++) begin
            cyc();
            wpat = {wpat[62:0], bus.fifo_wr};
            bpat = {bpat[62:0], busy};
            rpat = {rpat[62:0], |bus.req_ready};
            if (bus.fifo_wr) wcnt++;
            if (busy) bcnt++;
            if (tmo_pulse) begin
                tcnt++;
                if (tpos < 0) tpos = c;
            end
        end
    endtask

    task automatic chk_wr(input string tag, input int g, input logic [7:0] d);
        logic [10:0] got;
        got = (wq.size() > 0) ? wq.pop_front() : 11'h7ff;
        chk(tag, 32'(got), 32'({g[2:0], d}));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset dominates even with a requester valid and enable high.
        #2;
        bus.req_valid = 4'b0001;
        cfg_tx_enable = 1'b1;
        #20;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_wr", 32'(bus.fifo_wr), 0);
        chk("rst_wdata", 32'(bus.fifo_wdata), 0);
        chk("rst_tmo", 32'(tmo_pulse), 0);
        bus.req_valid = '0;
        en_s = 1'b1;
        @(negedge app_clk);
        reset_n = 1'b1;

        // Single requester, 3-byte message.
        send(0, 8'h41, 3);
        run(5);
        chk("t1_wr_pat", 32'(wpat[4:0]), 32'b01110);
        chk("t1_busy_pat", 32'(bpat[4:0]), 32'b01110);
        chk_wr("t1_b0", 0, 8'h41);
        chk_wr("t1_b1", 0, 8'h42);
        chk_wr("t1_b2", 0, 8'h43);

        // 1 and 3 together, then 0 which just released has lowest priority.
        send(1, 8'h11, 2);
        send(3, 8'h31, 2);
        send(0, 8'h01, 1);
        run(9);
        chk("t2_wr_pat", 32'(wpat[8:0]), 32'b011011010);
        chk("t2_busy_pat", 32'(bpat[8:0]), 32'b011011010);
        chk_wr("t2_b0", 1, 8'h11);
        chk_wr("t2_b1", 1, 8'h12);
        chk_wr("t2_b2", 3, 8'h31);
        chk_wr("t2_b3", 3, 8'h32);
        chk_wr("t2_b4", 0, 8'h01);

        // fifo_full for 5 cycles mid-message.
        send(2, 8'hA0, 4);
        run(3);
        chk("t3_wr_pre", 32'(wpat[2:0]), 32'b011);
        full_s = 1'b1;
        run(5);
        chk("t3_wr_full", 32'(wpat[4:0]), 0);
        chk("t3_rdy_full", 32'(rpat[4:0]), 0);
        chk("t3_busy_full", 32'(bpat[4:0]), 32'b11111);
        full_s = 1'b0;
        run(4);
        chk("t3_wr_post", 32'(wpat[3:0]), 32'b1100);
        chk_wr("t3_b0", 2, 8'hA0);
        chk_wr("t3_b1", 2, 8'hA1);
        chk_wr("t3_b2", 2, 8'hA2);
        chk_wr("t3_b3", 2, 8'hA3);

        // Enable dropped after byte 2 of 4; rr_ptr (3) retained.
        send(1, 8'hB0, 4);
        run(3);
        chk("t4_wr_pre", 32'(wpat[2:0]), 32'b011);
        en_s = 1'b0;
        run(3);
        chk("t4_wr_off", 32'(wpat[2:0]), 0);
        chk("t4_busy_off", 32'(bpat[2:0]), 32'b100);
        mq[1].delete();
        en_s = 1'b1;
        send(2, 8'hC2, 1);
        run(4);
        chk("t4_wr_re", 32'(wpat[3:0]), 32'b0100);
        chk_wr("t4_b0", 1, 8'hB0);
        chk_wr("t4_b1", 1, 8'hB1);
        chk_wr("t4_b2", 2, 8'hC2);
        // Search wraps from pointer 3 to requester 0; pointer becomes 1.
        send(0, 8'hF0, 1);
        run(3);
        chk("t4_wrap_pat", 32'(wpat[2:0]), 32'b010);
        chk_wr("t4_wrap", 0, 8'hF0);

        // Async reset mid-message, then tie 0 vs 2 from pointer 0.
        send(3, 8'hD0, 3);
        run(2);
        chk("t5_wr_pre", 32'(wpat[1:0]), 32'b01);
        chk_wr("t5_b0", 3, 8'hD0);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_wr", 32'(bus.fifo_wr), 0);
        chk("t5_rst_ready", 32'(bus.req_ready), 0);
        chk("t5_rst_grant", 32'(grant_id), 0);
        chk("t5_rst_wdata", 32'(bus.fifo_wdata), 0);
        mq[3].delete();
        run(1);
        chk("t5_rst_hold", 32'({busy, bus.fifo_wr}), 0);
        reset_n = 1'b1;
        send(0, 8'hE0, 1);
        send(2, 8'hE2, 1);
        run(5);
        chk("t5_wr_pat", 32'(wpat[4:0]), 32'b01010);
        chk_wr("t5_tie0", 0, 8'hE0);
        chk_wr("t5_tie1", 2, 8'hE2);

        // Owner stops valid after byte 1 while requester 1 waits.
        send(3, 8'h61, 2);
        send(1, 8'h71, 1);
        run(2);
        chk("t6_wr_pre", 32'(wpat[1:0]), 32'b01);
        chk_wr("t6_b0", 3, 8'h61);
        gate[3] = 1'b1;
        run(100);
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("t6_tmo_cnt", 32'(tcnt), 1);
        chk("t6_tmo_pos", 32'(tpos), 15);
        chk("t6_wr_cnt", 32'(wcnt), 1);
        chk_wr("t6_next", 1, 8'h71);
        gate[3] = 1'b0;
        run(5);
        chk("t6_wr_post", 32'(wpat[4:0]), 32'b01000);
        chk_wr("t6_b1", 3, 8'h62);
`else
        chk("t6_tmo_cnt", 32'(tcnt), 0);
        chk("t6_wr_cnt", 32'(wcnt), 0);
        chk("t6_busy_cnt", 32'(bcnt), 100);
        chk("t6_grant", 32'(grant_id), 3);
        gate[3] = 1'b0;
        run(5);
        chk("t6_wr_post", 32'(wpat[4:0]), 32'b10100);
        chk_wr("t6_b1", 3, 8'h62);
        chk_wr("t6_next", 1, 8'h71);
`endif

        chk("wq_empty", 32'(wq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Message-level round-robin arbiter sharing one UART transmit FIFO write port among NREQ byte-stream requesters (e.g. CPU, debug console, DMA).
- Sits in front of the UART TX FIFO, which feeds the TX serialiser FSM.
- A granted requester keeps the port until it sends its last byte, so messages never interleave on the serial line.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TMO_CYC, 1024, idle-grant timeout in app_clk cycles. Used only with UART_TX_ARB_TIMEOUT_EN.

Ports:
- app_clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cfg_tx_enable  input  1  transmit enable. 0 forces IDLE, all ready low.
- req_valid  input  NREQ  per-requester byte valid.
- req_data  input  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NREQ  marks last byte of a message; qualified by req_valid.
- req_ready  output  NREQ  per-requester accept.
- fifo_full  input  1  TX FIFO full.
- fifo_wr  output  1  TX FIFO write strobe.
- fifo_wdata  output  8  TX FIFO write data.
- grant_id  output  3  current owner index; valid when busy=1.
- busy  output  1  high in LOCK state.
- tmo_pulse  output  1  one-cycle pulse on timeout release; constant 0 without the macro.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, req_ready=0, fifo_wr=0, fifo_wdata=0, tmo_pulse=0, timeout counter=0.
- Transfer on requester i: xfer_i = req_valid[i] & req_ready[i].
- req_ready[i] = (state==LOCK) & (grant_id==i) & !fifo_full & cfg_tx_enable. Combinational.
- fifo_wr = OR of xfer_i. fifo_wdata = granted requester's req_data, combinational. No FIFO write latency beyond the combinational path; at most one byte per cycle.
- FSM states: IDLE, LOCK.
- IDLE, any req_valid and cfg_tx_enable=1:
  - Winner = first valid index searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - Register grant_id=winner; go to LOCK.
  - Arbitration costs exactly one cycle. No byte is accepted in IDLE.
- LOCK:
  - Stall while fifo_full=1 or req_valid[grant_id]=0. State is held.
  - xfer with req_last=1: go to IDLE, rr_ptr = grant_id+1, wrapping to 0 at NREQ.
  - Earliest re-grant is the next cycle, so a back-to-back message costs one bubble.
  - req_last without valid is ignored.
- Simultaneous requests: resolved strictly by rr_ptr order. After an owner releases, it has lowest priority in the next round.
- Single-byte message (valid+last on the first accepted byte) releases immediately after that byte.
- fifo_full asserting mid-message: ready drops the same cycle; no byte is lost or duplicated.
- Requester dropping valid mid-message: grant is held indefinitely (macro off).
- cfg_tx_enable=0: next edge forces state=IDLE and busy=0. rr_ptr is retained. A partially sent message is abandoned; software must resynchronise.
- Async reset mid-message: immediate return to reset values. No write is issued in the reset cycle.
- grant_id width is fixed at 3; upper bits are 0 when NREQ<8.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro, LOCK has a counter of clog2(TMO_CYC)+1 bits:
  - Cleared on entry to LOCK and on every xfer.
  - Increments each LOCK cycle where req_valid[grant_id]=0. Does not count fifo_full stalls while valid=1.
  - When count reaches TMO_CYC-1: state=IDLE, rr_ptr=grant_id+1, tmo_pulse=1 for one cycle, counter cleared.
- Without the macro: no counter, tmo_pulse tied to 0, grant is held until last byte.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - Typedef arb_state_e {IDLE=1'b0, LOCK=1'b1}.
  - Localparam GID_W=3.
  - Function rr_pick(valid, ptr) returning index and found flag.
- One natural sub-module: uart_rr_pick. Combinational round-robin priority picker, NREQ-parameterised, reusable by other UART/SPI arbiters.
- The FSM, pointer and timeout counter live in the top module.

Test Plan:
- Single requester 0, 3-byte message 0x41,0x42,0x43 (last on 0x43), fifo_full=0 → arbitration cycle, then fifo_wr high 3 consecutive cycles with bytes in order; busy falls after 0x43; rr_ptr=1.
- Requesters 1 and 3 valid together, rr_ptr=0 → 1 granted first; its 2-byte message completes, then 3 granted after one bubble; output bytes never interleave.
- fifo_full pulsed high for 5 cycles in the middle of a 4-byte message → req_ready low those cycles; FIFO receives exactly 4 bytes, none duplicated.
- cfg_tx_enable dropped after byte 2 of 4 → state IDLE next cycle, no further fifo_wr; re-enable with requester 2 valid → fresh arbitration.
- reset_n asserted mid-message → all outputs return to reset values asynchronously; after deassert, rr_ptr=0 and requester 0 wins a tie with requester 2.
- (UART_TX_ARB_TIMEOUT_EN, TMO_CYC=16) owner stops valid after byte 1 → tmo_pulse exactly 16 cycles after the last xfer; next requester granted; without the macro, grant is held for 100 cycles.
